// File: rtl/alu_uart_interface_pkg.sv
// Shared types and constants for the serial ALU operand loader.
package alu_uart_interface_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  function automatic logic is_loading(input state_t s);
    return (s == ST_WAIT_B) || (s == ST_WAIT_OP);
  endfunction

endpackage

// File: rtl/alu_uart_interface_timeout_counter.sv
// Inter-byte gap timer: counts enabled idle cycles, flags the terminal count.
module alu_uart_interface_timeout_counter #(
  parameter int TIMEOUT = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] TERM = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // expired is combinational so the caller can let a same-cycle byte win
  assign expired = enable && (count == TERM);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != TERM)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_uart_interface.sv
// Loads ALU operands A, B, OP from received UART bytes and sends the result back.
// state      | meaning
// ST_IDLE    | waiting for operand A byte
// ST_WAIT_B  | A loaded, waiting for operand B (gap timer running)
// ST_WAIT_OP | B loaded, waiting for opcode byte (gap timer running)
// ST_EXEC    | ALU settling for ALU_LAT cycles
// ST_WAIT_TX | result handed to transmitter, waiting for tx_done
module alu_uart_interface
  import alu_uart_interface_pkg::*;
#(
  parameter int N_BITS  = 8,
  parameter int N_OP    = 6,
  parameter int ALU_LAT = 1,
  parameter int TIMEOUT = 100000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_rx_data,
  input  logic              i_rx_done,
  input  logic              i_tx_done,
  input  logic [N_BITS-1:0] i_alu_res,
  output logic [N_BITS-1:0] o_alu_A,
  output logic [N_BITS-1:0] o_alu_B,
  output logic [N_OP-1:0]   o_alu_OP,
  output logic [N_BITS-1:0] o_tx_data,
  output logic              o_tx_start,
  output logic              o_busy,
  output logic              o_timeout,
  output logic              o_overrun
);

  localparam int LAT_W = $clog2(ALU_LAT + 1);

  state_t            state, state_d;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_d;
  logic [N_BITS-1:0] alu_a_d, alu_b_d, tx_data_d;
  logic [N_OP-1:0]   alu_op_d;
  logic              tx_start_d, busy_d, timeout_d, overrun_d;
  logic              gap_en, gap_clr, gap_expired;

  assign gap_en  = is_loading(state);
  assign gap_clr = !gap_en || i_rx_done;

  alu_uart_interface_timeout_counter #(.TIMEOUT(TIMEOUT)) u_gap (
    .clock   (clock),
    .reset   (reset),
    .enable  (gap_en),
    .clear   (gap_clr),
    .expired (gap_expired)
  );

  always_comb begin
    state_d    = state;
    lat_cnt_d  = lat_cnt;
    alu_a_d    = o_alu_A;
    alu_b_d    = o_alu_B;
    alu_op_d   = o_alu_OP;
    tx_data_d  = o_tx_data;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    overrun_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_rx_done) begin
          alu_a_d = i_rx_data;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done) begin
          alu_b_d = i_rx_data;
          state_d = ST_WAIT_OP;
        end else if (gap_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done) begin
          alu_op_d  = i_rx_data[N_OP-1:0];
          lat_cnt_d = LAT_W'(ALU_LAT - 1);
          state_d   = ST_EXEC;
        end else if (gap_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_EXEC: begin
        overrun_d = i_rx_done;
        if (lat_cnt == '0) begin
          tx_data_d  = i_alu_res;
          tx_start_d = 1'b1;
          state_d    = ST_WAIT_TX;
        end else begin
          lat_cnt_d = lat_cnt - 1'b1;
        end
      end
      ST_WAIT_TX: begin
        overrun_d = i_rx_done;
        // a tx_done coincident with our own start belongs to an earlier byte
        if (i_tx_done && !o_tx_start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      o_alu_A    <= '0;
      o_alu_B    <= '0;
      o_alu_OP   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state      <= state_d;
      lat_cnt    <= lat_cnt_d;
      o_alu_A    <= alu_a_d;
      o_alu_B    <= alu_b_d;
      o_alu_OP   <= alu_op_d;
      o_tx_data  <= tx_data_d;
      o_tx_start <= tx_start_d;
      o_busy     <= busy_d;
      o_timeout  <= timeout_d;
      o_overrun  <= overrun_d;
    end
  end

endmodule
